// File: rtl/bundle_pkg.sv
// rtl/bundle_pkg.sv - shared bundle types and widths
// Purpose: common width constant and types for blocks consuming the bundle signals.
//   BUNDLE_WIDTH : bits per bundle word (inp width)
//   index_t      : bit position within a word
//   word_t       : one assembled word
//   packed_t     : FIFO entry {partial, data}
package bundle_pkg;

  localparam int BUNDLE_WIDTH = 4;

  typedef logic [$clog2(BUNDLE_WIDTH)-1:0] index_t;
  typedef logic [BUNDLE_WIDTH-1:0]         word_t;

  typedef struct packed {
    logic  partial;
    word_t data;
  } packed_t;

endpackage

// File: rtl/bundle_packer_sync_fifo.sv
// rtl/bundle_packer_sync_fifo.sv - synchronous FIFO with pointer-compare full/empty
// Purpose: DEPTH-entry storage for completed words; head is read combinationally.
// Ports:
//   clock, reset_n : clock, asynchronous active-low reset
//   push, wdata    : write strobe and data (caller guarantees push is legal)
//   pop            : remove head (caller guarantees FIFO not empty)
//   rdata          : head entry
//   level          : occupancy 0..DEPTH
//   full, empty    : occupancy flags
module sync_fifo #(
  parameter  int W     = 5,
  parameter  int DEPTH = 4,
  localparam int AW    = $clog2(DEPTH)
) (
  input  logic          clock,
  input  logic          reset_n,
  input  logic          push,
  input  logic [W-1:0]  wdata,
  input  logic          pop,
  output logic [W-1:0]  rdata,
  output logic [AW:0]   level,
  output logic          full,
  output logic          empty
);

  localparam logic [AW:0] PTR_ONE = (AW+1)'(1);

  logic [W-1:0] mem_q [DEPTH];
  logic [W-1:0] mem_d [DEPTH];
  // Pointers carry one extra wrap bit so full and empty are distinguishable.
  logic [AW:0]  wr_ptr_q, wr_ptr_d;
  logic [AW:0]  rd_ptr_q, rd_ptr_d;

  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    // When full with a pop, the write slot equals the head slot being retired.
    if (push) begin
      mem_d[wr_ptr_q[AW-1:0]] = wdata;
      wr_ptr_d                = wr_ptr_q + PTR_ONE;
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + PTR_ONE;
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  assign rdata = mem_q[rd_ptr_q[AW-1:0]];
  assign empty = (wr_ptr_q == rd_ptr_q);
  assign full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                 (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign level = wr_ptr_q - rd_ptr_q;

endmodule

// File: rtl/bundle_packer.sv
// rtl/bundle_packer.sv - packs per-index bundle bits into words and queues them
// Purpose: collects one bit per index into a WIDTH-bit word; a sample at index
//   WIDTH-1 completes the word, which is pushed into a FIFO with a flag telling
//   whether any lower position was left unwritten since the previous push.
// Ports:
//   clock, reset_n     : clock, asynchronous active-low reset
//   in_valid           : sample strobe
//   in_index, in_bit   : bit position and sampled value
//   out_valid          : FIFO head holds a word
//   out_ready          : consumer takes the head word
//   out_data           : head word
//   out_partial        : head word had unwritten positions
//   level              : FIFO occupancy
//   overflow           : sticky, a completed word was dropped
module bundle_packer
  import bundle_pkg::*;
#(
  parameter  int WIDTH = BUNDLE_WIDTH,
  parameter  int DEPTH = 4,
  localparam int IW    = $clog2(WIDTH),
  localparam int LW    = $clog2(DEPTH) + 1
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             in_valid,
  input  logic [IW-1:0]    in_index,
  input  logic             in_bit,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic             out_partial,
  output logic [LW-1:0]    level,
  output logic             overflow
);

  localparam logic [IW-1:0]    LAST_INDEX = IW'(WIDTH - 1);
  localparam logic [WIDTH-1:0] TOP_MASK   = {1'b1, {(WIDTH-1){1'b0}}};

  logic [WIDTH-1:0] acc_q, acc_d;
  logic [WIDTH-1:0] seen_q, seen_d;
  logic             overflow_q, overflow_d;

  logic             complete;
  logic [WIDTH-1:0] word_data;
  logic             word_partial;
  logic             push;
  logic             pop;
  logic             fifo_full;
  logic             fifo_empty;
  logic [WIDTH:0]   fifo_rdata;

  assign complete = in_valid && (in_index == LAST_INDEX);
  assign pop      = out_valid && out_ready;
  // A full FIFO still takes the word when the head leaves in the same cycle.
  assign push     = complete && (!fifo_full || pop);

  always_comb begin
    word_data            = acc_q;
    word_data[WIDTH-1]   = in_bit;
    // The completing sample itself always fills the top position.
    word_partial         = ~&(seen_q | TOP_MASK);

    acc_d      = acc_q;
    seen_d     = seen_q;
    overflow_d = overflow_q;
    if (in_valid) begin
      acc_d[in_index]  = in_bit;
      seen_d[in_index] = 1'b1;
    end
    if (complete) begin
      seen_d = '0;
    end
    if (complete && fifo_full && !pop) begin
      overflow_d = 1'b1;
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      acc_q      <= '0;
      seen_q     <= '0;
      overflow_q <= 1'b0;
    end else begin
      acc_q      <= acc_d;
      seen_q     <= seen_d;
      overflow_q <= overflow_d;
    end
  end

  sync_fifo #(
    .W     (WIDTH + 1),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clock   (clock),
    .reset_n (reset_n),
    .push    (push),
    .wdata   ({word_partial, word_data}),
    .pop     (pop),
    .rdata   (fifo_rdata),
    .level   (level),
    .full    (fifo_full),
    .empty   (fifo_empty)
  );

  assign out_valid   = !fifo_empty;
  assign out_data    = fifo_rdata[WIDTH-1:0];
  assign out_partial = fifo_rdata[WIDTH];
  assign overflow    = overflow_q;

endmodule
